// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Helpers work on a fixed maximum width; callers truncate to their own WIDTH.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_WIDTH = 8;
  localparam int MAX_W     = 32;

  // Two's-complement negate when neg is set; the low WIDTH bits of the result are
  // the WIDTH-bit magnitude, so the most negative operand maps to 2^(WIDTH-1).
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

  function automatic logic [2*MAX_W-1:0] cond_neg_prod(input logic [2*MAX_W-1:0] v,
                                                       input logic neg);
    return neg ? (~v + (2*MAX_W)'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial-product bit per cycle, signed or
// unsigned per operation, valid/ready handshakes on both operand and result sides.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 2 * WIDTH + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic                r_neg;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_p;

  logic                w_accept;
  logic                w_last;
  logic [WIDTH-1:0]    w_a_mag;
  logic [WIDTH-1:0]    w_b_mag;
  logic                w_neg;
  logic [ACC_W-1:0]    w_acc_sum;
  logic [ACC_W-1:0]    w_acc_shift;

  assign w_accept = in_valid & (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_a_mag = WIDTH'(cond_neg(MAX_W'(a), is_signed & a[WIDTH-1]));
  assign w_b_mag = WIDTH'(cond_neg(MAX_W'(b), is_signed & b[WIDTH-1]));
  assign w_neg   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

  // Add the multiplicand into the upper half, then shift the whole accumulator right.
  assign w_acc_sum   = r_acc + (r_mplier[0] ? {1'b0, r_mcand, {WIDTH{1'b0}}} : '0);
  assign w_acc_shift = w_acc_sum >> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_neg    <= w_neg;
    end else if (r_state == BUSY) begin
      r_mplier <= r_mplier >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_shift;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last)
        r_p <= (2*WIDTH)'(cond_neg_prod((2*MAX_W)'(w_acc_shift[2*WIDTH-1:0]), r_neg));
    end
  end

  assign p = r_p;

endmodule
